// File: rtl/fft_frame_ctrl_pkg.sv
// rtl/fft_frame_ctrl_pkg.sv - shared defaults and state encoding for the FFT frame sequencer
//
// Purpose : default frame geometry, watchdog length and the FSM state type
//           used by fft_frame_ctrl and its frame buffers.
// Ports   : none (package).
package fft_frame_ctrl_pkg;

  localparam int DATA_WID_DEF     = 16;
  localparam int FFT_LEN_DEF      = 8;
  localparam int LOG2_FFT_LEN_DEF = 3;
  localparam int TIMEOUT_DEF      = 64;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - FFT_LEN-entry complex register bank with serial and parallel access
//
// Purpose : holds one frame of complex samples. Entries can be written one at
//           a time (serial write) or all at once (parallel load), and read one
//           at a time (serial read) or all at once (parallel read).
// Ports   :
//   clk_i, rst_i        clock, asynchronous active-high reset (bank -> 0)
//   wr_en_i/wr_idx_i    serial write strobe and entry index
//   wr_re_i/wr_im_i     serial write data
//   ld_en_i             parallel load strobe (wins over a serial write)
//   ld_re_i/ld_im_i     parallel load data, entry 0 in the LSBs
//   rd_idx_i            serial read index
//   rd_re_o/rd_im_o     serial read data
//   par_re_o/par_im_o   whole bank, entry 0 in the LSBs
module fft_frame_buf #(
  parameter int DATA_WID     = 16,
  parameter int FFT_LEN      = 8,
  parameter int LOG2_FFT_LEN = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [LOG2_FFT_LEN-1:0]     wr_idx_i,
  input  logic [DATA_WID-1:0]         wr_re_i,
  input  logic [DATA_WID-1:0]         wr_im_i,
  input  logic                        ld_en_i,
  input  logic [FFT_LEN*DATA_WID-1:0] ld_re_i,
  input  logic [FFT_LEN*DATA_WID-1:0] ld_im_i,
  input  logic [LOG2_FFT_LEN-1:0]     rd_idx_i,
  output logic [DATA_WID-1:0]         rd_re_o,
  output logic [DATA_WID-1:0]         rd_im_o,
  output logic [FFT_LEN*DATA_WID-1:0] par_re_o,
  output logic [FFT_LEN*DATA_WID-1:0] par_im_o
);

  logic [FFT_LEN*DATA_WID-1:0] re_q, re_d;
  logic [FFT_LEN*DATA_WID-1:0] im_q, im_d;

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (ld_en_i) begin
      re_d = ld_re_i;
      im_d = ld_im_i;
    end else if (wr_en_i) begin
      re_d[wr_idx_i*DATA_WID +: DATA_WID] = wr_re_i;
      im_d[wr_idx_i*DATA_WID +: DATA_WID] = wr_im_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign rd_re_o  = re_q[rd_idx_i*DATA_WID +: DATA_WID];
  assign rd_im_o  = im_q[rd_idx_i*DATA_WID +: DATA_WID];
  assign par_re_o = re_q;
  assign par_im_o = im_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer around fft_core64: serial in, parallel core, serial out
//
// Purpose : packs FFT_LEN serial samples into a frame, fires the core with a
//           one-cycle start, waits for done under a watchdog, captures the
//           results and drains them serially with an end-of-frame marker.
//           One frame in flight; input is back-pressured outside LOAD.
// Ports   :
//   clk, rst                      clock, asynchronous active-high reset
//   in_val/in_ready/in_re/in_im   serial sample input (valid/ready)
//   core_start                    one-cycle start pulse to the core
//   core_re_o/core_im_o           packed frame to the core, sample 0 in LSBs
//   core_done/core_re_i/core_im_i core result strobe and packed results
//   out_val/out_ready/out_re/out_im/out_last  serial result output
//   busy                          high in any state other than LOAD
//   err_timeout/clr_err           sticky watchdog error and its clear
//   frame_cnt                     count of fully drained frames (wraps)
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DATA_WID     = DATA_WID_DEF,
  parameter int FFT_LEN      = FFT_LEN_DEF,
  parameter int LOG2_FFT_LEN = LOG2_FFT_LEN_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_val,
  output logic                        in_ready,
  input  logic [DATA_WID-1:0]         in_re,
  input  logic [DATA_WID-1:0]         in_im,
  output logic                        core_start,
  output logic [FFT_LEN*DATA_WID-1:0] core_re_o,
  output logic [FFT_LEN*DATA_WID-1:0] core_im_o,
  input  logic                        core_done,
  input  logic [FFT_LEN*DATA_WID-1:0] core_re_i,
  input  logic [FFT_LEN*DATA_WID-1:0] core_im_i,
  output logic                        out_val,
  input  logic                        out_ready,
  output logic [DATA_WID-1:0]         out_re,
  output logic [DATA_WID-1:0]         out_im,
  output logic                        out_last,
  output logic                        busy,
  output logic                        err_timeout,
  input  logic                        clr_err,
  output logic [15:0]                 frame_cnt
);

  localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0]       WDOG_MAX = WDOG_W'(TIMEOUT - 1);
  localparam logic [LOG2_FFT_LEN-1:0] IDX_LAST = LOG2_FFT_LEN'(FFT_LEN - 1);

  state_e                  state_q, state_d;
  logic [LOG2_FFT_LEN-1:0] idx_q, idx_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    err_q, err_d;
  logic [15:0]             frame_q, frame_d;

  logic                    pack_wr;
  logic                    res_ld;
  logic                    err_set;
  logic [DATA_WID-1:0]     res_rd_re, res_rd_im;

  logic [DATA_WID-1:0]         unused_pack_rd_re, unused_pack_rd_im;
  logic [FFT_LEN*DATA_WID-1:0] unused_res_par_re, unused_res_par_im;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wdog_d     = '0;
    err_d      = err_q;
    frame_d    = frame_q;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_val    = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    pack_wr    = 1'b0;
    res_ld     = 1'b0;
    err_set    = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_val) begin
          pack_wr = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_FIRE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_FIRE: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          res_ld  = 1'b1;
          state_d = ST_UNLOAD;
        end else if (wdog_q == WDOG_MAX) begin
          // Abandon the frame; the input bank is simply overwritten next time.
          err_set = 1'b1;
          state_d = ST_LOAD;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        out_val  = 1'b1;
        out_last = (idx_q == IDX_LAST);
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            frame_d = frame_q + 16'd1;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // A watchdog hit in the same cycle as clr_err must not be lost.
    if (err_set) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  fft_frame_buf #(
    .DATA_WID     (DATA_WID),
    .FFT_LEN      (FFT_LEN),
    .LOG2_FFT_LEN (LOG2_FFT_LEN)
  ) u_pack_buf (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (pack_wr),
    .wr_idx_i (idx_q),
    .wr_re_i  (in_re),
    .wr_im_i  (in_im),
    .ld_en_i  (1'b0),
    .ld_re_i  ('0),
    .ld_im_i  ('0),
    .rd_idx_i (idx_q),
    .rd_re_o  (unused_pack_rd_re),
    .rd_im_o  (unused_pack_rd_im),
    .par_re_o (core_re_o),
    .par_im_o (core_im_o)
  );

  fft_frame_buf #(
    .DATA_WID     (DATA_WID),
    .FFT_LEN      (FFT_LEN),
    .LOG2_FFT_LEN (LOG2_FFT_LEN)
  ) u_res_buf (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (1'b0),
    .wr_idx_i ('0),
    .wr_re_i  ('0),
    .wr_im_i  ('0),
    .ld_en_i  (res_ld),
    .ld_re_i  (core_re_i),
    .ld_im_i  (core_im_i),
    .rd_idx_i (idx_q),
    .rd_re_o  (res_rd_re),
    .rd_im_o  (res_rd_im),
    .par_re_o (unused_res_par_re),
    .par_im_o (unused_res_par_im)
  );

  // Output data is forced to zero outside UNLOAD so stale results never show.
  assign out_re      = out_val ? res_rd_re : '0;
  assign out_im      = out_val ? res_rd_im : '0;
  assign err_timeout = err_q;
  assign frame_cnt   = frame_q;

endmodule
